// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Digit-scan scheduler and frame-aligned update controller for a four-digit
//   seven-segment display. A divider paces the 2-bit scan index. New
//   hex/point/LE content is double-buffered behind a load_req/load_ack
//   handshake and committed only on a frame boundary (scan 3 -> 0), so a
//   frame never shows mixed old and new data. While scanning is frozen
//   (en=0), a request commits on the next edge instead.
//
//   Optional feature macro: DISP_BLANK_EN
//     defined   -> blank is high for the first BLANK cycles of every digit slot
//     undefined -> blank is tied 0 and BLANK is ignored
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   en                scan enable (0 freezes divider, scan and blank)
//   load_req          commit request, held by requester until load_ack
//   hexs_in/points_in/LEs_in   staged display content
//   load_ack          one-cycle pulse after the commit edge
//   scan              current digit index 0..3
//   hexs/points/LEs   committed display content
//   blank             anode blanking window
//   frame_tick        one-cycle pulse after each 3 -> 0 scan wrap
module display_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load_req,
  input  logic [15:0] hexs_in,
  input  logic [3:0]  points_in,
  input  logic [3:0]  LEs_in,
  output logic        load_ack,
  output logic [1:0]  scan,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        blank,
  output logic        frame_tick
);

  localparam int              CW       = $clog2(DIV);
  localparam logic [CW-1:0]   DIV_LAST = CW'(DIV - 1);

  // Elaboration-time marker: an illegal DIV/BLANK pair produces this named
  // (empty) scope, which is easy to spot in the elaborated hierarchy.
  if (DIV < 2 || BLANK < 1 || BLANK >= DIV) begin : g_illegal_params
  end

  typedef struct packed {
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
  } disp_t;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    scan_q, scan_d;
  disp_t         disp_q, disp_d;
  logic          load_ack_q, load_ack_d;
  logic          frame_tick_q, frame_tick_d;
  logic          div_wrap, frame_edge, commit;

  always_comb begin
    div_wrap   = en && (div_cnt_q == DIV_LAST);
    frame_edge = div_wrap && (scan_q == 2'd3);

    div_cnt_d = div_cnt_q;
    scan_d    = scan_q;
    if (en) begin
      div_cnt_d = div_wrap ? '0 : div_cnt_q + CW'(1);
      if (div_wrap) scan_d = scan_q + 2'd1;
    end

    // load_ack_q masks the ack cycle so a request still held there is not
    // committed twice; a request seen after it is a fresh one.
    commit = load_req && !load_ack_q && (en ? frame_edge : 1'b1);

    disp_d       = commit ? disp_t'{hexs_in, points_in, LEs_in} : disp_q;
    load_ack_d   = commit;
    frame_tick_d = frame_edge;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      scan_q       <= 2'd0;
      disp_q       <= '0;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      scan_q       <= scan_d;
      disp_q       <= disp_d;
      load_ack_q   <= load_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef DISP_BLANK_EN
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK);

  logic blank_q, blank_d;

  // Compared against the next divider value so blank lines up with the
  // registered div_cnt; holds with the divider while frozen.
  always_comb begin
    blank_d = blank_q;
    if (en) blank_d = (div_cnt_d < BLANK_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) blank_q <= 1'b1;
    else     blank_q <= blank_d;
  end

  assign blank = blank_q;
`else
  assign blank = 1'b0;
`endif

  assign load_ack   = load_ack_q;
  assign scan       = scan_q;
  assign hexs       = disp_q.hexs;
  assign points     = disp_q.points;
  assign LEs        = disp_q.les;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV=4, BLANK=1). A behavioural
// model tracks the enabled-cycle position inside a frame as a plain integer
// and derives scan/blank/frame boundaries arithmetically from it.
module tb_display_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 4 * DIV;
`ifdef DISP_BLANK_EN
  localparam logic BLANK_RST = 1'b1;
`else
  localparam logic BLANK_RST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load_req = 1'b0;
  logic [15:0] hexs_in = '0;
  logic [3:0]  points_in = '0;
  logic [3:0]  LEs_in = '0;
  logic        load_ack, blank, frame_tick;
  logic [1:0]  scan;
  logic [15:0] hexs;
  logic [3:0]  points, LEs;

  int checks = 0;
  int failures = 0;

  display_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .load_req(load_req),
    .hexs_in(hexs_in), .points_in(points_in), .LEs_in(LEs_in),
    .load_ack(load_ack), .scan(scan), .hexs(hexs), .points(points),
    .LEs(LEs), .blank(blank), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_t = 0;       // enabled cycles into the current frame
  logic        m_ack = 1'b0, m_tick = 1'b0;
  logic [15:0] m_hexs = '0;
  logic [3:0]  m_points = '0, m_les = '0;
  logic [1:0]  m_scan;
  logic        m_blank, m_commit;

  always_comb begin
    m_scan   = 2'(m_t / DIV);
`ifdef DISP_BLANK_EN
    m_blank  = (m_t % DIV) < BLANK;
`else
    m_blank  = 1'b0;
`endif
    m_commit = load_req && !m_ack && (!en || m_t == FRAME - 1);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_t <= 0; m_ack <= 1'b0; m_tick <= 1'b0;
      m_hexs <= '0; m_points <= '0; m_les <= '0;
    end else begin
      m_tick <= en && (m_t == FRAME - 1);
      m_ack  <= m_commit;
      if (m_commit) begin
        m_hexs <= hexs_in; m_points <= points_in; m_les <= LEs_in;
      end
      if (en) m_t <= (m_t + 1) % FRAME;
    end
  end

  logic [28:0] obs, exp_v;
  assign obs   = {load_ack, frame_tick, blank, scan, hexs, points, LEs};
  assign exp_v = {m_ack, m_tick, m_blank, m_scan, m_hexs, m_points, m_les};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({load_ack, frame_tick, scan, hexs, points, LEs} !== 28'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {load_ack, frame_tick, scan, hexs, points, LEs});
    end
    checks++;
    if (blank !== BLANK_RST) begin
      failures++; $display("FAIL reset_blank got=%b want=%b", blank, BLANK_RST);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_sequencing();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL scan_model k=%0d got=%h want=%h", k, obs, exp_v);
      end
      checks++;
      if (scan !== 2'((k % 16) / 4)) begin
        failures++; $display("FAIL scan_index k=%0d got=%0d want=%0d", k, scan, (k % 16) / 4);
      end
      checks++;
      if (frame_tick !== (k % 16 == 0)) begin
        failures++; $display("FAIL scan_tick k=%0d got=%b want=%b", k, frame_tick, k % 16 == 0);
      end
      checks++;
      if (blank !== (BLANK_RST && (k % 4 == 0))) begin
        failures++; $display("FAIL scan_blank k=%0d got=%b want=%b", k, blank, BLANK_RST && (k % 4 == 0));
      end
    end
  endtask

  task automatic test_frame_commit();
    int n = 0;
    int acks = 0;
    while (scan !== 2'd1 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64) begin failures++; $display("FAIL fc_wait_scan1 got=timeout want=scan1"); end
    hexs_in = 16'h1234; points_in = 4'($urandom); LEs_in = 4'($urandom); load_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL fc_model i=%0d got=%h want=%h", i, obs, exp_v);
      end
      if (load_ack) begin
        acks++;
        checks++;
        if (hexs !== 16'h1234 || scan !== 2'd0) begin
          failures++; $display("FAIL fc_commit got=%h/scan%0d want=1234/scan0", hexs, scan);
        end
        load_req = 1'b0;
      end else if (acks == 0) begin
        checks++;
        if (hexs !== 16'h0000) begin
          failures++; $display("FAIL fc_early_update got=%h want=0000", hexs);
        end
      end
    end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL fc_ack_count got=%0d want=1", acks); end
  endtask

  task automatic test_same_edge();
    int n = 0;
    logic [15:0] h;
    while (m_t != FRAME - 1 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64) begin failures++; $display("FAIL se_wait got=timeout want=slot_end"); end
    h = 16'($urandom); hexs_in = h; points_in = 4'($urandom); LEs_in = 4'($urandom);
    load_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ack, frame_tick, scan, hexs} !== {1'b1, 1'b1, 2'd0, h}) begin
      failures++;
      $display("FAIL same_edge got=%h want=%h", {load_ack, frame_tick, scan, hexs}, {1'b1, 1'b1, 2'd0, h});
    end
    load_req = 1'b0;
    @(negedge clk);
    checks++;
    if (load_ack !== 1'b0 || obs !== exp_v) begin
      failures++; $display("FAIL same_edge_after got=%h want=%h", obs, exp_v);
    end
  endtask

  task automatic test_frozen();
    int n = 0;
    while (scan !== 2'd2 && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (n >= 64) begin failures++; $display("FAIL fz_wait got=timeout want=scan2"); end
    en = 1'b0; points_in = 4'b0101; load_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({points, load_ack, scan} !== {4'b0101, 1'b1, 2'd2}) begin
      failures++;
      $display("FAIL frozen_commit got=%h want=%h", {points, load_ack, scan}, {4'b0101, 1'b1, 2'd2});
    end
    load_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (scan !== 2'd2 || frame_tick !== 1'b0 || obs !== exp_v) begin
        failures++; $display("FAIL frozen_hold i=%0d got=%h want=%h", i, obs, exp_v);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_request();
    int ack_at = -1;
    int n = 0;
    logic [15:0] h;
    while (scan !== 2'd1 && n < 64) begin @(negedge clk); n++; end
    hexs_in = 16'($urandom); load_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; load_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_ack, frame_tick, scan, hexs, points, LEs, blank} !== {28'h0, BLANK_RST}) begin
      failures++; $display("FAIL rst_mid_req got=%h want=%h",
        {load_ack, frame_tick, scan, hexs, points, LEs, blank}, {28'h0, BLANK_RST});
    end
    rst = 1'b0;
    h = 16'($urandom); hexs_in = h; load_req = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL rst_req_model k=%0d got=%h want=%h", k, obs, exp_v);
      end
      if (load_ack) begin
        if (ack_at < 0) ack_at = k;
        load_req = 1'b0;
      end
    end
    checks++;
    if (ack_at != 16) begin failures++; $display("FAIL rst_rereq_ack_cycle got=%0d want=16", ack_at); end
    checks++;
    if (hexs !== h) begin failures++; $display("FAIL rst_rereq_data got=%h want=%h", hexs, h); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_v) begin
        failures++; $display("FAIL random i=%0d got=%h want=%h", i, obs, exp_v);
      end
      rst = 1'b0;
      if (load_req && load_ack) load_req = 1'b0;
      else if (!load_req && $urandom_range(0, 5) == 0) begin
        load_req = 1'b1;
        hexs_in = 16'($urandom); points_in = 4'($urandom); LEs_in = 4'($urandom);
      end
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 199) == 0) begin rst = 1'b1; load_req = 1'b0; end
    end
    rst = 1'b0; load_req = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan_sequencing();
    test_frame_commit();
    test_same_edge();
    test_frozen();
    test_reset_mid_request();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
